// File: rtl/display_bcd_converter_pkg.sv
// Shared definitions for the display binary-to-BCD converter.
package display_bcd_converter_pkg;

   // Converter FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Double-dabble digit correction: digits >= 5 get +3 before each shift.
   localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
   localparam logic [3:0] BCD_ADJUST_ADD       = 4'd3;

   // RAM address whose writes drive the display (also used by the RAM decode).
   localparam int unsigned DISPLAY_ADDR = 4095;

endpackage

// File: rtl/display_bcd_converter_bcd_digit_adjust.sv
// Single-digit double-dabble correction: adds 3 when the digit is >= 5.
module bcd_digit_adjust
   import display_bcd_converter_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Pre-shift correction so the doubled digit carries correctly into the next one.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= BCD_ADJUST_THRESHOLD) begin
         digit_o = digit_i + BCD_ADJUST_ADD;
      end
   end

endmodule

// File: rtl/display_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Outputs hold the last completed conversion so the displays never flicker.
module display_bcd_converter
   import display_bcd_converter_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned INT_DIGITS = 10
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                wenable,
   input  logic [WIDTH-1:0]    wvalue,
   output logic [4*DIGITS-1:0] bcd,
   output logic                valid,
   output logic                busy,
   output logic                overflow
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam int unsigned AccW = 4 * INT_DIGITS;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [AccW-1:0]     acc_q, acc_d;
   logic [AccW-1:0]     acc_adj;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                pend_q, pend_d;
   logic [WIDTH-1:0]    pend_val_q, pend_val_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                valid_q, valid_d;
   logic                ovf_q, ovf_d;
   logic                acc_hi_nz;

   // One correction cell per internal digit.
   for (genvar i = 0; i < INT_DIGITS; i++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit_i (acc_q[4*i +: 4]),
         .digit_o (acc_adj[4*i +: 4])
      );
   end

   // Digits above the displayed range flag overflow.
   if (INT_DIGITS > DIGITS) begin : g_hi
      assign acc_hi_nz = |acc_q[AccW-1:4*DIGITS];
   end else begin : g_no_hi
      assign acc_hi_nz = 1'b0;
   end

   // Next-state logic: FSM, datapath and pending-write capture.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      bcd_d      = bcd_q;
      valid_d    = valid_q;
      ovf_d      = ovf_q;

      // Writes during a conversion are parked; the last one wins.
      if (wenable && (state_q != ST_IDLE)) begin
         pend_d     = 1'b1;
         pend_val_d = wvalue;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (wenable) begin
               shift_d = wvalue;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            acc_d   = {acc_adj[AccW-2:0], shift_q[WIDTH-1]};
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_d   = acc_q[4*DIGITS-1:0];
            ovf_d   = acc_hi_nz;
            valid_d = 1'b1;
            // A write landing in this very cycle counts as pending too.
            if (wenable || pend_q) begin
               shift_d = wenable ? wvalue : pend_val_q;
               acc_d   = '0;
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         bcd_q      <= '0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         bcd_q      <= bcd_d;
         valid_q    <= valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bcd      = bcd_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_bcd_converter.sv
// Scoreboard bench for display_bcd_converter: stimulus pushes expected results,
// a monitor pops and compares them whenever the displayed result changes.
module tb_display_bcd_converter;

   localparam int unsigned WIDTH      = 32;
   localparam int unsigned DIGITS     = 8;
   localparam int unsigned INT_DIGITS = 10;
   localparam int          LAT        = WIDTH + 1;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                wenable;
   logic [WIDTH-1:0]    wvalue;
   logic [4*DIGITS-1:0] bcd;
   logic                valid;
   logic                busy;
   logic                overflow;

   display_bcd_converter #(
      .WIDTH      (WIDTH),
      .DIGITS     (DIGITS),
      .INT_DIGITS (INT_DIGITS)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .wenable  (wenable),
      .wvalue   (wvalue),
      .bcd      (bcd),
      .valid    (valid),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] bcd;
      logic        ovf;
      int          done;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Timing model of the converter's occupancy (edge numbers of DONE).
   int cur_done    = -1000;
   int pend_done   = 0;
   bit pend_exists = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Called at a negedge; the write is sampled at the next rising edge.
   task automatic do_write(input logic [31:0] v, input logic [31:0] eb, input logic eo,
                           input string nm);
      int   e;
      exp_t x;
      e = cyc + 1;
      if (pend_exists && e > cur_done) begin
         cur_done    = pend_done;
         pend_exists = 0;
      end
      x.bcd  = eb;
      x.ovf  = eo;
      x.name = nm;
      if (e > cur_done) begin
         cur_done = e + LAT;
         x.done   = cur_done;
         sb_q.push_back(x);
      end else if (pend_exists) begin
         x.done = pend_done;
         sb_q[sb_q.size()-1] = x;
      end else begin
         pend_done   = cur_done + LAT;
         pend_exists = 1;
         x.done      = pend_done;
         sb_q.push_back(x);
      end
      wenable = 1'b1;
      wvalue  = v;
      @(negedge clock);
      wenable = 1'b0;
      wvalue  = '0;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending results want 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: a new result is presented when valid rises or the shown value changes.
   initial begin
      logic [31:0] prev_bcd;
      logic        prev_ovf;
      logic        prev_valid;
      exp_t        x;
      prev_bcd   = '0;
      prev_ovf   = 1'b0;
      prev_valid = 1'b0;
      forever begin
         @(negedge clock);
         if (valid === 1'b1 && (prev_valid !== 1'b1 || bcd !== prev_bcd || overflow !== prev_ovf))
         begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_update: got bcd %h ovf %b want no update", bcd, overflow);
            end else begin
               x = sb_q.pop_front();
               chk({x.name, "_bcd"}, 64'(bcd), 64'(x.bcd));
               chk({x.name, "_ovf"}, 64'(overflow), 64'(x.ovf));
               chk({x.name, "_cycle"}, 64'(cyc), 64'(x.done));
            end
         end
         prev_valid = valid;
         prev_bcd   = bcd;
         prev_ovf   = overflow;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit low_seen;
      bit idle_bad;
      int e;
      int d;

      reset_n = 1'b0;
      wenable = 1'b0;
      wvalue  = '0;
      repeat (3) @(negedge clock);
      chk("rst_bcd", 64'(bcd), 64'h0);
      chk("rst_valid", 64'(valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ovf", 64'(overflow), 64'h0);
      reset_n = 1'b1;

      // No writes: outputs stay quiet.
      idle_bad = 0;
      repeat (20) begin
         @(negedge clock);
         if (bcd !== '0 || valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) idle_bad = 1;
      end
      chk("idle_quiet", 64'(idle_bad), 64'h0);

      // Plain conversion.
      do_write(32'd12345678, 32'h12345678, 1'b0, "dec12345678");
      chk("busy_rise", 64'(busy), 64'h1);
      wait_drain(60);
      chk("busy_fall", 64'(busy), 64'h0);
      chk("valid_set", 64'(valid), 64'h1);

      // All ones: 4294967295 shows low 8 digits with overflow.
      do_write(32'hFFFF_FFFF, 32'h94967295, 1'b1, "allones");
      wait_drain(60);

      // Back-to-back: 42, then 7 and 99 while shifting; only 99 follows.
      low_seen = 0;
      do_write(32'd42, 32'h42, 1'b0, "dec42");
      e = cyc;
      repeat (4) begin
         @(negedge clock);
         if (busy !== 1'b1) low_seen = 1;
      end
      do_write(32'd7, 32'h7, 1'b0, "dec7");
      repeat (4) begin
         @(negedge clock);
         if (busy !== 1'b1) low_seen = 1;
      end
      do_write(32'd99, 32'h99, 1'b0, "dec99");
      while (cyc < e + 2 * LAT - 1) begin
         @(negedge clock);
         if (busy !== 1'b1) low_seen = 1;
      end
      chk("busy_b2b", 64'(low_seen), 64'h0);
      wait_drain(80);

      // Write landing exactly in the DONE cycle of the prior conversion.
      do_write(32'd31, 32'h31, 1'b0, "dec31");
      d = cyc + LAT;
      while (cyc < d - 1) @(negedge clock);
      do_write(32'd100000000, 32'h0, 1'b1, "dec1e8");
      wait_drain(80);

      // Reset in the middle of converting 555.
      do_write(32'd555, 32'h555, 1'b0, "dec555");
      repeat (9) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("async_bcd", 64'(bcd), 64'h0);
      chk("async_valid", 64'(valid), 64'h0);
      chk("async_busy", 64'(busy), 64'h0);
      chk("async_ovf", 64'(overflow), 64'h0);
      sb_q.delete();
      cur_done    = -1000;
      pend_exists = 0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(negedge clock);
      chk("no_late_valid", 64'(valid), 64'h0);
      chk("no_late_bcd", 64'(bcd), 64'h0);
      chk("no_late_busy", 64'(busy), 64'h0);

      do_write(32'd5, 32'h5, 1'b0, "dec5");
      wait_drain(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
